// File: rtl/mux2to1_arbiter.sv
// rtl/mux2to1_arbiter.sv - round-robin arbiter sharing one mux2to1 datapath into a registered output stage

// Plain two-input word mux: select=0 passes data1, select=1 passes data2.
module mux2to1 #(
  parameter int N = 32
) (
  input  logic         select,
  input  logic [N-1:0] data1,
  input  logic [N-1:0] data2,
  output logic [N-1:0] dataOut
);

  assign dataOut = select ? data2 : data1;

endmodule

// Two requesters share one 32-bit path. The granted side drives the mux, and its word
// lands in a single-entry valid/ready output register.
module mux2to1_arbiter #(
  parameter int N         = 32,
  parameter int MAX_BURST = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req1,
  input  logic [N-1:0] data1,
  output logic         gnt1,
  input  logic         req2,
  input  logic [N-1:0] data2,
  output logic         gnt2,
  output logic         select,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic         out_src
);

  localparam int CW = $clog2(MAX_BURST + 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] GRANT1 = 2'd1;
  localparam logic [1:0] GRANT2 = 2'd2;

  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BURST);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [1:0]    state;
  logic [1:0]    state_next;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_inc;
  logic [CW-1:0] cnt_next;
  logic          last;        // 0: requester 1 was granted most recently, 1: requester 2
  logic          last_next;
  logic          space;
  logic          at_max;
  logic          at_max_next;
  logic          xfer;
  logic [N-1:0]  mux_out;

  mux2to1 #(.N(N)) u_mux (
    .select  (select),
    .data1   (data1),
    .data2   (data2),
    .dataOut (mux_out)
  );

  // The output register can take a word if it is empty or being drained this cycle.
  assign space  = !out_valid || out_ready;
  assign at_max = (cnt == CNT_MAX);

  // A saturated burst only blocks the holder when the other side is actually waiting.
  assign gnt1 = !rst && (state == GRANT1) && req1 && space && !(req2 && at_max);
  assign gnt2 = !rst && (state == GRANT2) && req2 && space && !(req1 && at_max);
  assign xfer = gnt1 || gnt2;

  // The count after this cycle's transfer decides the hand-over, so the switch happens
  // on the edge that ends the last burst word and the next grant starts with no gap.
  assign cnt_inc     = (xfer && !at_max) ? cnt + CNT_ONE : cnt;
  assign at_max_next = (cnt_inc == CNT_MAX);

  // Next-state decode: round-robin tie-break from IDLE, burst-limited hand-over in GRANTx.
  always_comb begin
    state_next = state;
    cnt_next   = cnt_inc;
    last_next  = last;
    case (state)
      IDLE: begin
        if (req1 && (!req2 || last)) begin
          state_next = GRANT1;
          cnt_next   = '0;
          last_next  = 1'b0;
        end else if (req2) begin
          state_next = GRANT2;
          cnt_next   = '0;
          last_next  = 1'b1;
        end
      end
      GRANT1: begin
        if (req2 && (!req1 || at_max_next)) begin
          state_next = GRANT2;
          cnt_next   = '0;
          last_next  = 1'b1;
        end else if (!req1 && !req2) begin
          state_next = IDLE;
        end
      end
      GRANT2: begin
        if (req1 && (!req2 || at_max_next)) begin
          state_next = GRANT1;
          cnt_next   = '0;
          last_next  = 1'b0;
        end else if (!req1 && !req2) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Arbitration state; select is registered alongside the state it decodes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      last   <= 1'b1;
      select <= 1'b0;
    end else begin
      state  <= state_next;
      cnt    <= cnt_next;
      last   <= last_next;
      select <= (state_next == GRANT2);
    end
  end

  // Single-entry output stage: load on transfer, clear on drain, hold otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= 1'b0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= mux_out;
      out_src   <= select;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux2to1_arbiter.sv
// tb/tb_mux2to1_arbiter.sv - scoreboard bench for mux2to1_arbiter

module tb_mux2to1_arbiter;

  localparam int MAXB = 4;

  logic        clk;
  logic        rst;
  logic        req1;
  logic [31:0] data1;
  logic        gnt1;
  logic        req2;
  logic [31:0] data2;
  logic        gnt2;
  logic        select;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_src;

  int checks = 0;
  int errors = 0;

  // reference model state
  int          m_state;   // 0 idle, 1 grant1, 2 grant2
  int          m_cnt;
  bit          m_last;
  bit          m_valid;
  logic [32:0] exp_q[$];
  logic        src_log[$];

  // values seen at the most recent sample point
  logic        obs_gnt1;
  logic        obs_gnt2;
  logic        obs_select;
  logic        obs_valid;
  logic [31:0] obs_data;
  logic        obs_src;
  logic [31:0] held;

  mux2to1_arbiter #(.N(32), .MAX_BURST(MAXB)) dut (
    .clk       (clk),
    .rst       (rst),
    .req1      (req1),
    .data1     (data1),
    .gnt1      (gnt1),
    .req2      (req2),
    .data2     (data2),
    .gnt2      (gnt2),
    .select    (select),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_src   (out_src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: compare at the falling edge, then advance the model past the rising edge.
  task automatic tick();
    bit          e1;
    bit          e2;
    bit          sp;
    logic [32:0] w;
    e1 = 1'b0;
    e2 = 1'b0;
    @(negedge clk);
    obs_gnt1   = gnt1;
    obs_gnt2   = gnt2;
    obs_select = select;
    obs_valid  = out_valid;
    obs_data   = out_data;
    obs_src    = out_src;
    if (rst) begin
      check("rst_gnt1", {31'd0, gnt1}, 32'd0);
      check("rst_gnt2", {31'd0, gnt2}, 32'd0);
    end else begin
      sp = !m_valid || out_ready;
      e1 = (m_state == 1) && req1 && sp && !(req2 && m_cnt == MAXB);
      e2 = (m_state == 2) && req2 && sp && !(req1 && m_cnt == MAXB);
      check("gnt1", {31'd0, gnt1}, {31'd0, e1});
      check("gnt2", {31'd0, gnt2}, {31'd0, e2});
      check("select", {31'd0, select}, {31'd0, (m_state == 2)});
      check("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
      if (out_valid && out_ready) src_log.push_back(out_src);
      if (m_valid && out_ready && out_valid) begin
        if (exp_q.size() == 0) begin
          check("sb_underflow", 32'(exp_q.size()), 32'd1);
        end else begin
          w = exp_q.pop_front();
          check("out_data", out_data, w[31:0]);
          check("out_src", {31'd0, out_src}, {31'd0, w[32]});
        end
      end
      if (e1) exp_q.push_back({1'b0, data1});
      if (e2) exp_q.push_back({1'b1, data2});
    end
    @(posedge clk);
    #1;
    if (rst) begin
      m_state = 0;
      m_cnt   = 0;
      m_last  = 1'b1;
      m_valid = 1'b0;
      exp_q.delete();
    end else begin
      if (e1 || e2) m_valid = 1'b1;
      else if (out_ready) m_valid = 1'b0;
      if ((e1 || e2) && m_cnt < MAXB) m_cnt++;
      case (m_state)
        0: begin
          if (req1 && req2) m_state = m_last ? 1 : 2;
          else if (req1) m_state = 1;
          else if (req2) m_state = 2;
          if (m_state != 0) begin
            m_cnt  = 0;
            m_last = (m_state == 2);
          end
        end
        1: begin
          if (req2 && (!req1 || m_cnt == MAXB)) begin
            m_state = 2; m_cnt = 0; m_last = 1'b1;
          end else if (!req1 && !req2) begin
            m_state = 0;
          end
        end
        default: begin
          if (req1 && (!req2 || m_cnt == MAXB)) begin
            m_state = 1; m_cnt = 0; m_last = 1'b0;
          end else if (!req1 && !req2) begin
            m_state = 0;
          end
        end
      endcase
    end
    if (e1) data1 = $urandom();
    if (e2) data2 = $urandom();
  endtask

  initial begin
    m_state = 0; m_cnt = 0; m_last = 1'b1; m_valid = 1'b0;
    rst = 1'b1; req1 = 1'b1; req2 = 1'b1; out_ready = 1'b1;
    data1 = 32'h0; data2 = 32'h0;
    @(posedge clk);
    #1;

    // reset holds grants off even with both requests up
    tick();
    tick();
    check("rst_valid", {31'd0, obs_valid}, 32'd0);
    check("rst_select", {31'd0, obs_select}, 32'd0);

    // single requester latency and unlimited burst
    rst = 1'b0; req1 = 1'b1; req2 = 1'b0; data1 = 32'h11111111;
    tick();
    check("lat_c0_gnt1", {31'd0, obs_gnt1}, 32'd0);
    tick();
    check("lat_c1_gnt1", {31'd0, obs_gnt1}, 32'd1);
    tick();
    check("lat_c2_valid", {31'd0, obs_valid}, 32'd1);
    check("lat_c2_data", obs_data, 32'h11111111);
    check("lat_c2_src", {31'd0, obs_src}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      tick();
      check("solo_burst_gnt1", {31'd0, obs_gnt1}, 32'd1);
    end
    req1 = 1'b0;
    tick();
    tick();

    // contention from reset: bursts of MAXB, req1 first, no output bubbles
    rst = 1'b1;
    tick();
    rst = 1'b0; req1 = 1'b1; req2 = 1'b1;
    src_log.delete();
    for (int i = 0; i < 18; i++) tick();
    check("cont_words", 32'(src_log.size()), 32'd16);
    for (int i = 0; i < 16 && i < src_log.size(); i++)
      check("cont_src_seq", {31'd0, src_log[i]}, 32'((i / MAXB) % 2));

    // fairness: after idling, the other requester wins the next tie
    req1 = 1'b0; req2 = 1'b0;
    tick();
    tick();
    req1 = 1'b1; req2 = 1'b1;
    tick();
    tick();
    check("fair_select", {31'd0, obs_select}, 32'd1);
    check("fair_gnt2", {31'd0, obs_gnt2}, 32'd1);
    req1 = 1'b0; req2 = 1'b0;
    tick();
    tick();
    tick();

    // backpressure: word held stable, grants withheld, then resumes same cycle
    req1 = 1'b1;
    tick();
    tick();
    out_ready = 1'b0;
    tick();
    held = obs_data;
    check("bp_gnt1_first", {31'd0, obs_gnt1}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("bp_gnt1", {31'd0, obs_gnt1}, 32'd0);
      check("bp_data_stable", obs_data, held);
    end
    out_ready = 1'b1;
    tick();
    check("bp_resume_gnt1", {31'd0, obs_gnt1}, 32'd1);
    check("bp_deliver", obs_data, held);
    req1 = 1'b0;
    tick();
    tick();
    tick();

    // requester 1 drops mid-burst, then reset discards the pending word
    req1 = 1'b1; req2 = 1'b0;
    tick();
    req2 = 1'b1;
    tick();
    tick();
    req1 = 1'b0;
    tick();
    tick();
    check("drop_select", {31'd0, obs_select}, 32'd1);
    check("drop_gnt2", {31'd0, obs_gnt2}, 32'd1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; req1 = 1'b0; req2 = 1'b0;
    tick();
    check("rst_mid_valid", {31'd0, obs_valid}, 32'd0);
    check("rst_mid_select", {31'd0, obs_select}, 32'd0);
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
